seven_seg_scan_capture: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Watches the scanned segment bus (o_LED) and digit-select bus (o_digitSelect) of the display block, waits for each digit to settle, and decodes the glyph back to a hex nibble.
- Assembles a full 4-digit frame and publishes it as a 16-bit value with a one-cycle valid pulse.
- Used in self-checking benches and for on-chip loopback of the display path.

---
 rtl/seven_seg_pkg.sv | 41 ++++
 rtl/seven_seg_decoder.sv | 40 ++++
 rtl/seven_seg_scan_capture.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared glyph table and constants for the 7-segment display path
// Shared by the scan driver and the scan capture so both agree on the encoding.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 4;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // gfedcba, active-high
   localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
   localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
   localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
   localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
   localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
   localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
   localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
   localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
   localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
   localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
   localparam logic [6:0] SEG_GLYPH_A = 7'h77;
   localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
   localparam logic [6:0] SEG_GLYPH_C = 7'h39;
   localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
   localparam logic [6:0] SEG_GLYPH_E = 7'h79;
   localparam logic [6:0] SEG_GLYPH_F = 7'h71;
   localparam logic [6:0] SEG_BLANK   = 7'h00;

   typedef enum logic [1:0] {
      SCAN_IDLE,
      SCAN_SETTLE,
      SCAN_HOLD
   } scan_state_e;

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - combinational segment pattern to hex nibble decoder
// Blank and unknown glyphs both read as nibble 0; only unknown ones flag invalid.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [7:0] i_seg,
   output logic [3:0] o_nibble,
   output logic       o_dp,
   output logic       o_blank,
   output logic       o_invalid
);

   always_comb begin
      o_nibble  = 4'h0;
      o_invalid = 1'b0;
      o_dp      = i_seg[SEG_DP];
      o_blank   = (i_seg[SEG_G:SEG_A] == SEG_BLANK);
      case (i_seg[SEG_G:SEG_A])
         SEG_GLYPH_0: o_nibble = 4'h0;
         SEG_GLYPH_1: o_nibble = 4'h1;
         SEG_GLYPH_2: o_nibble = 4'h2;
         SEG_GLYPH_3: o_nibble = 4'h3;
         SEG_GLYPH_4: o_nibble = 4'h4;
         SEG_GLYPH_5: o_nibble = 4'h5;
         SEG_GLYPH_6: o_nibble = 4'h6;
         SEG_GLYPH_7: o_nibble = 4'h7;
         SEG_GLYPH_8: o_nibble = 4'h8;
         SEG_GLYPH_9: o_nibble = 4'h9;
         SEG_GLYPH_A: o_nibble = 4'hA;
         SEG_GLYPH_B: o_nibble = 4'hB;
         SEG_GLYPH_C: o_nibble = 4'hC;
         SEG_GLYPH_D: o_nibble = 4'hD;
         SEG_GLYPH_E: o_nibble = 4'hE;
         SEG_GLYPH_F: o_nibble = 4'hF;
         SEG_BLANK:   o_nibble = 4'h0;
         default:     o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// rtl/seven_seg_scan_capture.sv - captures a scanned 4-digit 7-segment display back into a 16-bit frame
// Each digit is captured once per scan after its select and segments hold steady.
module seven_seg_scan_capture
   import seven_seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int SEL_ACTIVE_LOW = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [7:0]              i_LED,
   input  logic [NUM_DIGITS-1:0]   i_digitSelect,
   output logic [4*NUM_DIGITS-1:0] o_value,
   output logic [NUM_DIGITS-1:0]   o_dp,
   output logic [NUM_DIGITS-1:0]   o_blank,
   output logic                    o_error,
   output logic                    o_valid,
   output logic                    o_stale
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] SEL_INV = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
   localparam logic [NUM_DIGITS-1:0] ALL_DIGITS = {NUM_DIGITS{1'b1}};

   logic [7:0]              led_q, prev_seg_q, seg_n;
   logic [NUM_DIGITS-1:0]   sel_q, prev_sel_q, sel_n;
   scan_state_e             state_q, state_d;
   logic [SW-1:0]           settle_q, settle_d;
   logic [TW-1:0]           timeout_q, timeout_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic                    stale_q, stale_d;
   logic [4*NUM_DIGITS-1:0] slot_val_q, value_q;
   logic [NUM_DIGITS-1:0]   slot_dp_q, slot_blank_q, slot_err_q;
   logic [NUM_DIGITS-1:0]   dp_q, blank_q;
   logic                    error_q, valid_q;
   logic                    capture, publish, sample_same;
   logic [3:0]              dec_nibble;
   logic                    dec_dp, dec_blank, dec_invalid;

   assign seg_n       = led_q ^ SEG_INV;
   assign sel_n       = sel_q ^ SEL_INV;
   assign sample_same = (sel_n == prev_sel_q) && (seg_n == prev_seg_q);
   assign publish     = (mask_q == ALL_DIGITS);

   seven_seg_decoder u_decoder (
      .i_seg     (seg_n),
      .o_nibble  (dec_nibble),
      .o_dp      (dec_dp),
      .o_blank   (dec_blank),
      .o_invalid (dec_invalid)
   );

   // The cycle that enters SETTLE already counts as the first stable sample.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      capture  = 1'b0;
      case (state_q)
         SCAN_IDLE: begin
            settle_d = '0;
            if ($onehot(sel_n)) begin
               if (SETTLE_CYCLES <= 1) begin
                  capture  = 1'b1;
                  state_d  = SCAN_HOLD;
                  settle_d = SETTLE_MAX;
               end else begin
                  state_d  = SCAN_SETTLE;
                  settle_d = SW'(1);
               end
            end
         end
         SCAN_SETTLE: begin
            if (!sample_same) begin
               state_d  = SCAN_IDLE;
               settle_d = '0;
            end else if (settle_q == SETTLE_MAX - 1'b1) begin
               capture  = 1'b1;
               state_d  = SCAN_HOLD;
               settle_d = SETTLE_MAX;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         SCAN_HOLD: begin
            if (sel_n != prev_sel_q) begin
               state_d  = SCAN_IDLE;
               settle_d = '0;
            end
         end
         default: begin
            state_d  = SCAN_IDLE;
            settle_d = '0;
         end
      endcase
   end

   // A capture on the timeout cycle keeps the frame alive.
   always_comb begin
      mask_d    = mask_q;
      timeout_d = timeout_q;
      stale_d   = stale_q;
      if (publish) begin
         mask_d  = '0;
         stale_d = 1'b0;
      end
      if (capture) begin
         mask_d    = mask_q | sel_n;
         timeout_d = '0;
      end else begin
         if (timeout_q != TIMEOUT_MAX) begin
            timeout_d = timeout_q + 1'b1;
         end
         if (timeout_q == TIMEOUT_MAX - 1'b1) begin
            mask_d  = '0;
            stale_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         led_q        <= '0;
         sel_q        <= '0;
         prev_seg_q   <= '0;
         prev_sel_q   <= '0;
         state_q      <= SCAN_IDLE;
         settle_q     <= '0;
         timeout_q    <= '0;
         mask_q       <= '0;
         stale_q      <= 1'b0;
         slot_val_q   <= '0;
         slot_dp_q    <= '0;
         slot_blank_q <= '0;
         slot_err_q   <= '0;
         value_q      <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         error_q      <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         led_q      <= i_LED;
         sel_q      <= i_digitSelect;
         prev_seg_q <= seg_n;
         prev_sel_q <= sel_n;
         state_q    <= state_d;
         settle_q   <= settle_d;
         timeout_q  <= timeout_d;
         mask_q     <= mask_d;
         stale_q    <= stale_d;
         valid_q    <= publish;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (capture && sel_n[k]) begin
               slot_val_q[4*k +: 4] <= dec_nibble;
               slot_dp_q[k]         <= dec_dp;
               slot_blank_q[k]      <= dec_blank;
               slot_err_q[k]        <= dec_invalid;
            end
         end
         if (publish) begin
            value_q <= slot_val_q;
            dp_q    <= slot_dp_q;
            blank_q <= slot_blank_q;
            error_q <= |slot_err_q;
         end
      end
   end

   assign o_value = value_q;
   assign o_dp    = dp_q;
   assign o_blank = blank_q;
   assign o_error = error_q;
   assign o_valid = valid_q;
   assign o_stale = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// tb/tb_seven_seg_scan_capture.sv - directed bench for seven_seg_scan_capture
module tb_seven_seg_scan_capture;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  a_led, b_led;
   logic [3:0]  a_sel, b_sel;
   logic [15:0] a_value, b_value;
   logic [3:0]  a_dp, b_dp, a_blank, b_blank;
   logic        a_error, b_error, a_valid, b_valid, a_stale, b_stale;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int a_vcnt = 0;
   int a_vcyc = 0;
   int b_vcnt = 0;

   seven_seg_scan_capture #(
      .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1024), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
   ) dut_a (
      .i_clk(clk), .i_rst(rst), .i_LED(a_led), .i_digitSelect(a_sel),
      .o_value(a_value), .o_dp(a_dp), .o_blank(a_blank), .o_error(a_error),
      .o_valid(a_valid), .o_stale(a_stale)
   );

   seven_seg_scan_capture #(
      .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(1024), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
   ) dut_b (
      .i_clk(clk), .i_rst(rst), .i_LED(b_led), .i_digitSelect(b_sel),
      .o_value(b_value), .o_dp(b_dp), .o_blank(b_blank), .o_error(b_error),
      .o_valid(b_valid), .o_stale(b_stale)
   );

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (a_valid) begin
         a_vcnt = a_vcnt + 1;
         a_vcyc = cyc;
      end
      if (b_valid) b_vcnt = b_vcnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_a(input logic [3:0] sel, input logic [7:0] led, input int n);
      a_sel = sel;
      a_led = led;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_a(input int k, input logic [7:0] pat);
      drive_a(4'b0001 << k, pat, 8);
      drive_a(4'b0000, 8'h00, 2);
   endtask

   task automatic drive_b(input logic [3:0] sel, input logic [7:0] led, input int n);
      b_sel = ~sel;
      b_led = ~led;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_b(input int k, input logic [7:0] pat);
      drive_b(4'b0001 << k, pat, 8);
      drive_b(4'b0000, 8'h00, 2);
   endtask

   int v0, c0;

   initial begin
      rst = 1'b1;
      a_sel = 4'h0; a_led = 8'h00;
      b_sel = 4'hF; b_led = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_value", a_value, 16'h0000);
      check_eq("rst_flags", {a_dp, a_blank, a_error, a_valid, a_stale}, 11'h000);
      check_eq("rst_b_value", b_value, 16'h0000);

      // basic frame, latency from last digit to o_valid
      v0 = a_vcnt;
      scan_a(0, 8'h4F);
      scan_a(1, 8'h06);
      scan_a(2, 8'h5B);
      c0 = cyc;
      drive_a(4'b1000, 8'h3F, 8);
      drive_a(4'b0000, 8'h00, 2);
      check_eq("basic_vcnt", a_vcnt - v0, 1);
      check_eq("basic_latency", a_vcyc - c0, 6);
      check_eq("basic_value", a_value, 16'h0213);
      check_eq("basic_error", a_error, 1'b0);
      check_eq("basic_blank", a_blank, 4'b0000);
      check_eq("basic_dp", a_dp, 4'b0000);

      // async reset in the middle of SETTLE on the last digit
      v0 = a_vcnt;
      scan_a(0, 8'h3F);
      scan_a(1, 8'h3F);
      scan_a(2, 8'h3F);
      drive_a(4'b1000, 8'h06, 3);
      #3;
      rst = 1'b1;
      #1;
      check_eq("async_rst_value", a_value, 16'h0000);
      check_eq("async_rst_valid", a_valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_a(4'b1000, 8'h06, 8);
      drive_a(4'b0000, 8'h00, 2);
      check_eq("post_rst_novalid", a_vcnt - v0, 0);
      check_eq("post_rst_value", a_value, 16'h0000);

      // segment glitch on digit 2 never settles
      v0 = a_vcnt;
      scan_a(0, 8'h7F);
      scan_a(1, 8'h77);
      for (int i = 0; i < 6; i++) drive_a(4'b0100, (i % 2) ? 8'h6D : 8'h7D, 2);
      drive_a(4'b0000, 8'h00, 2);
      scan_a(3, 8'h79);
      check_eq("glitch_novalid", a_vcnt - v0, 0);
      scan_a(2, 8'h7D);
      check_eq("glitch_vcnt", a_vcnt - v0, 1);
      check_eq("glitch_digit2", a_value[11:8], 4'h6);
      check_eq("glitch_value", a_value, 16'hE6A8);

      // invalid glyph and blank digit
      v0 = a_vcnt;
      scan_a(0, 8'h06);
      scan_a(1, 8'h49);
      scan_a(2, 8'h66);
      scan_a(3, 8'h00);
      check_eq("inv_vcnt", a_vcnt - v0, 1);
      check_eq("inv_value", a_value, 16'h0401);
      check_eq("inv_error", a_error, 1'b1);
      check_eq("inv_blank", a_blank, 4'b1000);

      // multi-hot select, then timeout discards the partial frame
      v0 = a_vcnt;
      scan_a(3, 8'h3F);
      drive_a(4'b0011, 8'h3F, 20);
      drive_a(4'b0000, 8'h00, 2);
      scan_a(2, 8'h5B);
      check_eq("multihot_novalid", a_vcnt - v0, 0);
      drive_a(4'b0000, 8'h00, 1000);
      check_eq("stale_early", a_stale, 1'b0);
      drive_a(4'b0000, 8'h00, 40);
      check_eq("stale_set", a_stale, 1'b1);
      check_eq("stale_novalid", a_vcnt - v0, 0);
      check_eq("stale_value_kept", a_value, 16'h0401);
      scan_a(0, 8'h5B);
      scan_a(1, 8'h4F);
      check_eq("timeout_discard", a_vcnt - v0, 0);
      check_eq("stale_sticky", a_stale, 1'b1);
      scan_a(2, 8'h6F);
      scan_a(3, 8'h71);
      check_eq("recover_vcnt", a_vcnt - v0, 1);
      check_eq("recover_value", a_value, 16'hF932);
      check_eq("recover_stale", a_stale, 1'b0);
      check_eq("recover_error", a_error, 1'b0);

      // inverted polarity instance, dp on digit 0
      check_eq("b_stale_before", b_stale, 1'b1);
      v0 = b_vcnt;
      scan_b(0, 8'hCF);
      scan_b(1, 8'h06);
      scan_b(2, 8'h5B);
      scan_b(3, 8'h3F);
      check_eq("inv_pol_vcnt", b_vcnt - v0, 1);
      check_eq("inv_pol_value", b_value, 16'h0213);
      check_eq("inv_pol_dp", b_dp, 4'b0001);
      check_eq("inv_pol_blank", b_blank, 4'b0000);
      check_eq("inv_pol_stale", b_stale, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
